// File: rtl/code_seq_counter_if.sv
// Bus bundle for the hgfe code-sequence counter: count/load controls in,
// registered digit codes plus terminal-count and load-reject status out.
interface code_seq_counter_if #(
  parameter int NDIG = 2
);
  logic              en;
  logic              up;
  logic              load;
  logic [4*NDIG-1:0] load_code;
  logic [4*NDIG-1:0] code;
  logic              tc;
  logic              load_err;

  // Controller side: drives the counter and observes its state.
  modport master (
    output en,
    output up,
    output load,
    output load_code,
    input  code,
    input  tc,
    input  load_err
  );

  // Counter side.
  modport slave (
    input  en,
    input  up,
    input  load,
    input  load_code,
    output code,
    output tc,
    output load_err
  );
endinterface

// File: rtl/code_seq_counter.sv
// Multi-digit up/down counter whose digits walk the ten-entry hgfe code
// table instead of plain binary. Each digit keeps a 0..9 index; the code
// nibble is registered alongside it so downstream converters only ever see
// legal table entries. Parallel load is all-or-nothing: one invalid nibble
// rejects the whole word and raises a one-cycle load_err pulse.
module code_seq_counter #(
  parameter int NDIG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  code_seq_counter_if.slave    bus
);

  localparam logic [3:0] IDX_MAX = 4'd9;
  localparam logic [3:0] IDX_MIN = 4'd0;

  // Table index -> hgfe code. Indices above 9 are never held in state.
  function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
    logic [3:0] c;
    c = 4'b0000;
    case (idx)
      4'd0:    c = 4'b0000;
      4'd1:    c = 4'b0001;
      4'd2:    c = 4'b0011;
      4'd3:    c = 4'b0100;
      4'd4:    c = 4'b0101;
      4'd5:    c = 4'b0111;
      4'd6:    c = 4'b1001;
      4'd7:    c = 4'b1011;
      4'd8:    c = 4'b1100;
      4'd9:    c = 4'b1101;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  // hgfe code -> {valid, index}. Codes outside the table come back invalid.
  function automatic logic [4:0] code_to_idx(input logic [3:0] c);
    logic [4:0] r;
    r = 5'b0_0000;
    case (c)
      4'b0000: r = {1'b1, 4'd0};
      4'b0001: r = {1'b1, 4'd1};
      4'b0011: r = {1'b1, 4'd2};
      4'b0100: r = {1'b1, 4'd3};
      4'b0101: r = {1'b1, 4'd4};
      4'b0111: r = {1'b1, 4'd5};
      4'b1001: r = {1'b1, 4'd6};
      4'b1011: r = {1'b1, 4'd7};
      4'b1100: r = {1'b1, 4'd8};
      4'b1101: r = {1'b1, 4'd9};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Per-digit state and derived signals, packed digit-major.
  logic [NDIG-1:0][3:0] idx_reg;
  logic [NDIG-1:0][3:0] idx_next;
  logic [NDIG-1:0][3:0] step_idx;
  logic [NDIG-1:0][3:0] load_idx;
  logic [NDIG-1:0][3:0] code_next;
  logic [4*NDIG-1:0]    code_reg;
  logic [NDIG-1:0]      load_valid;
  logic [NDIG-1:0]      digit_max;
  logic [NDIG-1:0]      digit_min;
  // carry_up[k]: every digit below k sits at 9 (digit k may increment).
  // borrow_dn[k]: every digit below k sits at 0 (digit k may decrement).
  logic [NDIG:0]        carry_up;
  logic [NDIG:0]        borrow_dn;
  logic                 load_ok;
  logic                 load_reject;
  logic                 load_err_reg;

  assign carry_up[0]  = 1'b1;
  assign borrow_dn[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      logic [4:0] dec;

      // Decode this digit's load nibble once; validity and index come out together.
      assign dec             = code_to_idx(bus.load_code[4*gi +: 4]);
      assign load_valid[gi]  = dec[4];
      assign load_idx[gi]    = dec[3:0];

      assign digit_max[gi]   = (idx_reg[gi] == IDX_MAX);
      assign digit_min[gi]   = (idx_reg[gi] == IDX_MIN);
      assign carry_up[gi+1]  = carry_up[gi]  & digit_max[gi];
      assign borrow_dn[gi+1] = borrow_dn[gi] & digit_min[gi];

      // Candidate index for a count step: only digits whose lower neighbours
      // are all at the wrap point move; the rest hold.
      assign step_idx[gi] =
        bus.up ? (carry_up[gi]  ? (digit_max[gi] ? IDX_MIN : idx_reg[gi] + 4'd1) : idx_reg[gi])
               : (borrow_dn[gi] ? (digit_min[gi] ? IDX_MAX : idx_reg[gi] - 4'd1) : idx_reg[gi]);

      // Code register input follows the next index, keeping code and index in lockstep.
      assign code_next[gi] = idx_to_code(idx_next[gi]);

      assign bus.code[4*gi +: 4] = code_reg[4*gi +: 4];
    end
  endgenerate

  assign load_ok     = &load_valid;
  assign load_reject = bus.load & ~load_ok;

  // Next-state select: a load (valid or not) blocks counting; a rejected
  // load leaves every digit untouched.
  always_comb begin
    idx_next = idx_reg;
    if (bus.load) begin
      if (load_ok) begin
        idx_next = load_idx;
      end
    end else if (bus.en) begin
      idx_next = step_idx;
    end
  end

  // State, code and reject-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg      <= '0;
      code_reg     <= '0;
      load_err_reg <= 1'b0;
    end else begin
      idx_reg      <= idx_next;
      code_reg     <= code_next;
      load_err_reg <= load_reject;
    end
  end

  assign bus.load_err = load_err_reg;

  // Terminal count is combinational so a cascaded counter can use it as its
  // enable in the same cycle as the wrapping step.
  assign bus.tc = bus.en & ~bus.load & ~rst &
                  (bus.up ? carry_up[NDIG] : borrow_dn[NDIG]);

endmodule
